// File: rtl/branch_resolver.sv
// Execute-side branch resolver: tracks fetch predictions in an in-order FIFO,
// trains the predictor on resolution and flushes/redirects on mispredict.
// Optional performance counters are enabled with `define BRANCH_PERF_EN.
module branch_resolver #(
    parameter int DEPTH        = 8,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_push,
    input  logic [31:0] pc_if,
    input  logic        pre_jmp_status,
    input  logic [31:0] pre_jmp_target,
    output logic        if_ready,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_is_jmp,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic [31:0] pc_ex,
    output logic        opt_is_jmp,
    output logic [31:0] ifjmp_target,
    output logic        jmp_res,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_misses
);

    // Handshake: a prediction is consumed when if_push && if_ready are both
    // high at a rising clk edge; anything pushed while if_ready=0 is lost.
    // ex_valid has no back-pressure and is only acted on in IDLE.

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [2:0]         flush_cnt;

    logic [31:0]        pc_mem     [DEPTH];
    logic               taken_mem  [DEPTH];
    logic [31:0]        target_mem [DEPTH];

    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               full;
    logic               empty;
    logic               do_pop;
    logic               do_push;
    logic               pop_entry;
    logic               mispredict;
    logic               taken_jmp;
    logic [31:0]        head_pc;
    logic               head_taken;
    logic [31:0]        head_target;
    logic [31:0]        redirect_next;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // An empty FIFO resolves against a not-taken default entry at the EX pc.
    always_comb begin
        head_pc     = ex_pc;
        head_taken  = 1'b0;
        head_target = 32'd0;
        if (!empty) begin
            head_pc     = pc_mem[rd_ptr];
            head_taken  = taken_mem[rd_ptr];
            head_target = target_mem[rd_ptr];
        end
    end

    assign taken_jmp     = ex_is_jmp && ex_taken;
    assign do_pop        = ex_valid && (state == IDLE);
    assign pop_entry     = do_pop && !empty;
    assign redirect_next = taken_jmp ? ex_target : (ex_pc + 32'd4);

    always_comb begin
        mispredict = 1'b0;
        if (do_pop) begin
            if (ex_is_jmp && (ex_taken != head_taken))
                mispredict = 1'b1;
            if (taken_jmp && (ex_target != head_target))
                mispredict = 1'b1;
            if (!ex_is_jmp && head_taken)
                mispredict = 1'b1;
            if (head_pc != ex_pc)
                mispredict = 1'b1;
        end
    end

    // A push colliding with a mispredict belongs to the wrong path.
    assign do_push = if_push && if_ready && !mispredict;

    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[wr_ptr]     <= pc_if;
            taken_mem[wr_ptr]  <= pre_jmp_status;
            target_mem[wr_ptr] <= pre_jmp_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || mispredict) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_entry)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop_entry})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // FSM: next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (mispredict) state_next = FLUSH;
            FLUSH:   if (flush_cnt == 3'd1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        flush    = 1'b0;
        if_ready = 1'b0;
        case (state)
            IDLE:    if_ready = !full;
            FLUSH:   flush    = 1'b1;
            default: if_ready = 1'b0;
        endcase
    end

    // Remaining flush cycles; reaching zero hands control back to IDLE.
    always_ff @(posedge clk) begin
        if (rst)
            flush_cnt <= 3'd0;
        else if (mispredict)
            flush_cnt <= 3'(FLUSH_CYCLES);
        else if (state == FLUSH)
            flush_cnt <= flush_cnt - 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            redirect_pc <= 32'd0;
        else if (mispredict)
            redirect_pc <= redirect_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opt_is_jmp   <= 1'b0;
            pc_ex        <= 32'd0;
            ifjmp_target <= 32'd0;
            jmp_res      <= 1'b0;
        end else begin
            opt_is_jmp <= do_pop && ex_is_jmp;
            if (do_pop && ex_is_jmp) begin
                pc_ex        <= ex_pc;
                ifjmp_target <= ex_target;
                jmp_res      <= ex_taken;
            end
        end
    end

`ifdef BRANCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branches <= 32'd0;
            perf_misses   <= 32'd0;
        end else begin
            if (do_pop && ex_is_jmp)
                perf_branches <= perf_branches + 32'd1;
            if (mispredict)
                perf_misses <= perf_misses + 32'd1;
        end
    end
`else
    assign perf_branches = 32'd0;
    assign perf_misses   = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: predictions, mispredict flushes,
// FIFO capacity, redirect wrap, reset during flush and perf counters.
module tb_branch_resolver;

    logic        clk;
    logic        rst;
    logic        if_push;
    logic [31:0] pc_if;
    logic        pre_jmp_status;
    logic [31:0] pre_jmp_target;
    logic        if_ready;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_jmp;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic [31:0] pc_ex;
    logic        opt_is_jmp;
    logic [31:0] ifjmp_target;
    logic        jmp_res;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] perf_branches;
    logic [31:0] perf_misses;

    int checks;
    int errors;
    int flush_len;
    logic redirect_stable;

    branch_resolver #(.DEPTH(8), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .if_push(if_push), .pc_if(pc_if),
        .pre_jmp_status(pre_jmp_status), .pre_jmp_target(pre_jmp_target),
        .if_ready(if_ready),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_jmp(ex_is_jmp),
        .ex_taken(ex_taken), .ex_target(ex_target),
        .pc_ex(pc_ex), .opt_is_jmp(opt_is_jmp), .ifjmp_target(ifjmp_target),
        .jmp_res(jmp_res), .flush(flush), .redirect_pc(redirect_pc),
        .perf_branches(perf_branches), .perf_misses(perf_misses)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drivers: entered on a negedge, return on the next negedge, so the
    // caller observes outputs from the edge that consumed the stimulus.
    task automatic do_reset();
        rst = 1'b1;
        if_push = 1'b0; pc_if = '0; pre_jmp_status = 1'b0; pre_jmp_target = '0;
        ex_valid = 1'b0; ex_pc = '0; ex_is_jmp = 1'b0; ex_taken = 1'b0; ex_target = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] tg);
        if_push = 1'b1; pc_if = pc; pre_jmp_status = pt; pre_jmp_target = tg;
        @(negedge clk);
        if_push = 1'b0;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic isj, input logic tk,
                           input logic [31:0] tg);
        ex_valid = 1'b1; ex_pc = pc; ex_is_jmp = isj; ex_taken = tk; ex_target = tg;
        @(negedge clk);
        ex_valid = 1'b0;
    endtask

    task automatic push_and_resolve(input logic [31:0] ppc, input logic [31:0] rpc);
        if_push = 1'b1; pc_if = ppc; pre_jmp_status = 1'b0; pre_jmp_target = '0;
        ex_valid = 1'b1; ex_pc = rpc; ex_is_jmp = 1'b0; ex_taken = 1'b0; ex_target = '0;
        @(negedge clk);
        if_push = 1'b0; ex_valid = 1'b0;
    endtask

    // Counts the flush window (bounded) and records redirect_pc stability.
    task automatic wait_flush(output int n, output logic stable);
        logic [31:0] first;
        first  = redirect_pc;
        stable = 1'b1;
        n      = 0;
        while (flush === 1'b1 && n < 20) begin
            if (redirect_pc !== first) stable = 1'b0;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (if_ready !== 1'b1 || flush !== 1'b0 || opt_is_jmp !== 1'b0 ||
            pc_ex !== 32'd0 || redirect_pc !== 32'd0 || jmp_res !== 1'b0 ||
            ifjmp_target !== 32'd0 || perf_branches !== 32'd0 || perf_misses !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: if_ready=%b flush=%b opt=%b pc_ex=%h redir=%h pb=%0d pm=%0d required 1 0 0 0 0 0 0",
                     if_ready, flush, opt_is_jmp, pc_ex, redirect_pc, perf_branches, perf_misses);
        end
    endtask

    task automatic test_correct_taken();
        push(32'h100, 1'b1, 32'h200);
        resolve(32'h100, 1'b1, 1'b1, 32'h200);
        checks++;
        if (flush !== 1'b0 || opt_is_jmp !== 1'b1 || pc_ex !== 32'h100 ||
            jmp_res !== 1'b1 || ifjmp_target !== 32'h200) begin
            errors++;
            $display("FAIL correct_taken: flush=%b opt=%b pc_ex=%h res=%b tgt=%h required 0 1 100 1 200",
                     flush, opt_is_jmp, pc_ex, jmp_res, ifjmp_target);
        end
        @(negedge clk);
        checks++;
        if (opt_is_jmp !== 1'b0 || pc_ex !== 32'h100 || flush !== 1'b0) begin
            errors++;
            $display("FAIL train_pulse_hold: opt=%b pc_ex=%h flush=%b required 0 100 0",
                     opt_is_jmp, pc_ex, flush);
        end
    endtask

    task automatic test_direction_miss();
        push(32'h104, 1'b0, 32'h0);
        resolve(32'h104, 1'b1, 1'b1, 32'h300);
        checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h300 || if_ready !== 1'b0 ||
            opt_is_jmp !== 1'b1 || jmp_res !== 1'b1 || pc_ex !== 32'h104) begin
            errors++;
            $display("FAIL dir_miss_start: flush=%b redir=%h ready=%b opt=%b res=%b pc_ex=%h required 1 300 0 1 1 104",
                     flush, redirect_pc, if_ready, opt_is_jmp, jmp_res, pc_ex);
        end
        @(negedge clk);
        checks++;
        if (if_ready !== 1'b0 || flush !== 1'b1) begin
            errors++;
            $display("FAIL dir_miss_ready: ready=%b flush=%b required 0 1", if_ready, flush);
        end
        wait_flush(flush_len, redirect_stable);
        checks++;
        if (flush_len !== 1 || redirect_stable !== 1'b1 || if_ready !== 1'b1) begin
            errors++;
            $display("FAIL dir_miss_window: remaining=%0d stable=%b ready=%b required 1 1 1",
                     flush_len, redirect_stable, if_ready);
        end
        // Empty FIFO: a non-branch at any pc must resolve cleanly.
        resolve(32'h500, 1'b0, 1'b0, 32'h0);
        checks++;
        if (flush !== 1'b0) begin
            errors++;
            $display("FAIL dir_miss_empty: flush=%b required 0", flush);
        end
    endtask

    task automatic test_nonbranch_pred_taken();
        push(32'h108, 1'b1, 32'h400);
        resolve(32'h108, 1'b0, 1'b0, 32'h0);
        checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h10C || opt_is_jmp !== 1'b0) begin
            errors++;
            $display("FAIL nonbranch_taken: flush=%b redir=%h opt=%b required 1 10c 0",
                     flush, redirect_pc, opt_is_jmp);
        end
        wait_flush(flush_len, redirect_stable);
        checks++;
        if (flush_len !== 2 || redirect_stable !== 1'b1) begin
            errors++;
            $display("FAIL nonbranch_window: len=%0d stable=%b required 2 1", flush_len, redirect_stable);
        end
    endtask

    task automatic test_target_miss();
        push(32'h200, 1'b1, 32'h300);
        resolve(32'h200, 1'b1, 1'b1, 32'h310);
        checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h310 || ifjmp_target !== 32'h310) begin
            errors++;
            $display("FAIL target_miss: flush=%b redir=%h tgt=%h required 1 310 310",
                     flush, redirect_pc, ifjmp_target);
        end
        wait_flush(flush_len, redirect_stable);
    endtask

    task automatic test_pc_mismatch();
        push(32'h600, 1'b0, 32'h0);
        resolve(32'h604, 1'b0, 1'b0, 32'h0);
        checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h608) begin
            errors++;
            $display("FAIL pc_mismatch: flush=%b redir=%h required 1 608", flush, redirect_pc);
        end
        // Pushes and resolves during the flush must be ignored.
        push_and_resolve(32'h900, 32'h904);
        wait_flush(flush_len, redirect_stable);
        checks++;
        if (flush_len !== 1 || redirect_pc !== 32'h608) begin
            errors++;
            $display("FAIL flush_ignores: remaining=%0d redir=%h required 1 608", flush_len, redirect_pc);
        end
        resolve(32'h700, 1'b0, 1'b0, 32'h0);
        checks++;
        if (flush !== 1'b0) begin
            errors++;
            $display("FAIL flush_push_dropped: flush=%b required 0", flush);
        end
    endtask

    task automatic test_full_fifo();
        for (int i = 0; i < 8; i++) push(32'h1000 + 32'(i * 4), 1'b0, 32'h0);
        checks++;
        if (if_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: ready=%b required 0", if_ready);
        end
        push(32'h2000, 1'b0, 32'h0);
        // Push while full is dropped; the pop still drains the head.
        push_and_resolve(32'h2004, 32'h1000);
        checks++;
        if (flush !== 1'b0 || if_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_push_pop: flush=%b ready=%b required 0 1", flush, if_ready);
        end
        // At 7 entries a simultaneous push+pop keeps occupancy at 7.
        push_and_resolve(32'h3000, 32'h1004);
        checks++;
        if (flush !== 1'b0 || if_ready !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_count: flush=%b ready=%b required 0 1", flush, if_ready);
        end
        push(32'h3004, 1'b0, 32'h0);
        checks++;
        if (if_ready !== 1'b0) begin
            errors++;
            $display("FAIL refill_full: ready=%b required 0", if_ready);
        end
        for (int i = 2; i < 8; i++) begin
            resolve(32'h1000 + 32'(i * 4), 1'b0, 1'b0, 32'h0);
            checks++;
            if (flush !== 1'b0) begin
                errors++;
                $display("FAIL drain_%0d: flush=%b required 0", i, flush);
            end
        end
        resolve(32'h3000, 1'b0, 1'b0, 32'h0);
        resolve(32'h3004, 1'b0, 1'b0, 32'h0);
        checks++;
        if (flush !== 1'b0 || if_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain_tail: flush=%b ready=%b required 0 1", flush, if_ready);
        end
    endtask

    task automatic test_target_wrap();
        push(32'hFFFF_FFFC, 1'b1, 32'h40);
        resolve(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        checks++;
        if (flush !== 1'b1 || redirect_pc !== 32'h0) begin
            errors++;
            $display("FAIL target_wrap: flush=%b redir=%h required 1 00000000", flush, redirect_pc);
        end
        wait_flush(flush_len, redirect_stable);
    endtask

    task automatic test_reset_in_flush();
        push(32'h800, 1'b0, 32'h0);
        resolve(32'h800, 1'b1, 1'b1, 32'h880);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (flush !== 1'b0 || if_ready !== 1'b1 || redirect_pc !== 32'h0 || opt_is_jmp !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_flush: flush=%b ready=%b redir=%h opt=%b required 0 1 0 0",
                     flush, if_ready, redirect_pc, opt_is_jmp);
        end
    endtask

    task automatic test_perf();
        logic [31:0] exp_b;
        logic [31:0] exp_m;
`ifdef BRANCH_PERF_EN
        exp_b = 32'd3;
        exp_m = 32'd1;
`else
        exp_b = 32'd0;
        exp_m = 32'd0;
`endif
        do_reset();
        push(32'h700, 1'b1, 32'h800);
        resolve(32'h700, 1'b1, 1'b1, 32'h800);
        push(32'h704, 1'b0, 32'h0);
        resolve(32'h704, 1'b1, 1'b0, 32'h0);
        resolve(32'h708, 1'b0, 1'b0, 32'h0);
        push(32'h70C, 1'b0, 32'h0);
        resolve(32'h70C, 1'b1, 1'b1, 32'h900);
        wait_flush(flush_len, redirect_stable);
        checks++;
        if (perf_branches !== exp_b || perf_misses !== exp_m) begin
            errors++;
            $display("FAIL perf_counts: branches=%0d misses=%0d required %0d %0d",
                     perf_branches, perf_misses, exp_b, exp_m);
        end
        do_reset();
        checks++;
        if (perf_branches !== 32'd0 || perf_misses !== 32'd0) begin
            errors++;
            $display("FAIL perf_reset: branches=%0d misses=%0d required 0 0",
                     perf_branches, perf_misses);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        @(negedge clk);
        do_reset();
        test_reset();
        test_correct_taken();
        test_direction_miss();
        test_nonbranch_pred_taken();
        test_target_miss();
        test_pc_mismatch();
        test_full_fifo();
        test_target_wrap();
        test_reset_in_flush();
        test_perf();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
